// File: rtl/mm_pkg.sv
// mm_pkg: shared button indices and auto-repeat state encoding for the input front end.
package mm_pkg;
    localparam int BTN_S = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
    localparam int BTN_U = 3;
    localparam int BTN_D = 4;
    localparam int N_BTN = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;
endpackage

// File: rtl/btn_channel.sv
// btn_channel: 2-FF synchroniser, debounce and optional auto-repeat for one raw input.
module btn_channel
    import mm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_level
);
    localparam int  CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int  RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int  RW    = $clog2(RMAX + 1);
    localparam bit  RPT   = REPEAT_EN && (REPEAT_DELAY > 0);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    r_sync;
    logic          r_q;
    logic [CW-1:0] r_c;
    logic [RW-1:0] r_r;
    rpt_state_e    r_st;
    logic          r_pulse;
    logic          w_s;
    logic          w_accept;
    logic          w_rise;
    logic          w_rpt_hit;

    assign w_s       = r_sync[1];
    assign w_accept  = (w_s != r_q) && (r_c == C_LAST);
    assign w_rise    = w_accept && w_s;
    // Repeat events only while the debounced level is still high.
    assign w_rpt_hit = RPT && r_q && (((r_st == DELAY) && (r_r == R_DLY)) ||
                                      ((r_st == REPEAT) && (r_r == R_PER)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_q     <= 1'b0;
            r_c     <= '0;
            r_r     <= '0;
            r_st    <= IDLE;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_pulse <= w_rise || w_rpt_hit;
            if (w_s == r_q) begin
                r_c <= '0;
            end else if (w_accept) begin
                r_q <= w_s;
                r_c <= '0;
            end else begin
                r_c <= r_c + 1'b1;
            end
            if (RPT && w_rise) begin
                r_st <= DELAY;
                r_r  <= '0;
            end else if (!RPT || !r_q) begin
                r_st <= IDLE;
                r_r  <= '0;
            end else begin
                case (r_st)
                    DELAY: begin
                        r_st <= (r_r == R_DLY) ? REPEAT : DELAY;
                        r_r  <= (r_r == R_DLY) ? '0 : r_r + 1'b1;
                    end
                    REPEAT: r_r <= (r_r == R_PER) ? '0 : r_r + 1'b1;
                    default: r_r <= '0;
                endcase
            end
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_q;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions N_BTN buttons plus the mode switch into debounced levels
// and single-cycle press/repeat strobes.
module btn_conditioner
    import mm_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 2000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b11000,
    parameter int               REPEAT_DELAY    = 50000000,
    parameter int               REPEAT_PERIOD   = 15000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] i_btn_raw,
    input  logic             i_sw_raw,
    output logic [N_BTN-1:0] o_btn_pulse,
    output logic [N_BTN-1:0] o_btn_held,
    output logic             o_sw_stable
);
    localparam logic [N_BTN:0] MASK = {1'b0, REPEAT_MASK};

    logic [N_BTN:0] w_raw;
    logic [N_BTN:0] w_pulse;
    logic [N_BTN:0] w_level;
    logic           w_unused_sw_pulse;

    assign w_raw = {i_sw_raw, i_btn_raw};

    // The top channel is the switch: level only, never repeats.
    for (genvar g = 0; g <= N_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (MASK[g]),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (w_raw[g]),
            .o_pulse(w_pulse[g]),
            .o_level(w_level[g])
        );
    end

    assign o_btn_pulse       = w_pulse[N_BTN-1:0];
    assign o_btn_held        = w_level[N_BTN-1:0];
    assign o_sw_stable       = w_level[N_BTN];
    assign w_unused_sw_pulse = w_pulse[N_BTN];
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios with a scoreboard of expected pulse edges.
module tb_btn_conditioner;
    typedef struct {
        int         e;
        logic [4:0] m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic       sw_raw;
    logic [4:0] btn_pulse;
    logic [4:0] btn_held;
    logic       sw_stable;

    exp_t sb[$];
    int   e = 0;
    int   e0;
    int   n_assert = 0;
    int   n_fail = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_MASK    (5'b11000),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_btn_raw  (btn_raw),
        .i_sw_raw   (sw_raw),
        .o_btn_pulse(btn_pulse),
        .o_btn_held (btn_held),
        .o_sw_stable(sw_stable)
    );

    always #5 clk = ~clk;

    // Merge into the time-ordered list so simultaneous channels share one entry.
    function automatic void push(int at, logic [4:0] m);
        exp_t x;
        x.e = at;
        x.m = m;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].e == at) begin
                sb[i].m = sb[i].m | m;
                return;
            end
            if (sb[i].e > at) begin
                sb.insert(i, x);
                return;
            end
        end
        sb.push_back(x);
    endfunction

    task automatic chk(string tag, logic [4:0] obs, logic [4:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, e, obs, expv);
        end
    endtask

    task automatic step(int n);
        exp_t       x;
        logic [4:0] expv;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            e++;
            expv = '0;
            if (sb.size() > 0 && sb[0].e == e) begin
                x    = sb.pop_front();
                expv = x.m;
            end
            chk("pulse", btn_pulse, expv);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_raw = '0;
        sw_raw  = 1'b0;
        #12;
        chk("rst_pulse", btn_pulse, 5'b0);
        chk("rst_held", btn_held, 5'b0);
        chk("rst_sw", {4'b0, sw_stable}, 5'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3);

        // clean press on S: one pulse, no repeat, no pulse on release
        e0 = e;
        btn_raw[0] = 1'b1;
        push(e0 + 6, 5'b00001);
        step(5);
        chk("s_held_pre", btn_held, 5'b00000);
        step(1);
        chk("s_held", btn_held, 5'b00001);
        step(14);
        btn_raw[0] = 1'b0;
        step(5);
        chk("s_held_rel_pre", btn_held, 5'b00001);
        step(1);
        chk("s_held_rel", btn_held, 5'b00000);
        step(4);

        // bounce on R, then steady
        btn_raw[2] = 1'b1; step(1);
        btn_raw[2] = 1'b0; step(2);
        btn_raw[2] = 1'b1; step(3);
        btn_raw[2] = 1'b0; step(1);
        btn_raw[2] = 1'b1;
        e0 = e;
        push(e0 + 6, 5'b00100);
        step(5);
        chk("r_held_pre", btn_held, 5'b00000);
        step(1);
        chk("r_held", btn_held, 5'b00100);
        step(10);
        btn_raw[2] = 1'b0;
        step(10);
        chk("r_held_rel", btn_held, 5'b00000);

        // auto-repeat on U
        e0 = e;
        btn_raw[3] = 1'b1;
        push(e0 + 6, 5'b01000);
        push(e0 + 16, 5'b01000);
        for (int k = 19; k <= 28; k += 3) push(e0 + k, 5'b01000);
        step(10);
        chk("u_held", btn_held, 5'b01000);
        step(14);
        btn_raw[3] = 1'b0;
        step(5);
        chk("u_held_rel_pre", btn_held, 5'b01000);
        step(1);
        chk("u_held_rel", btn_held, 5'b00000);
        step(5);

        // switch with a dropout
        sw_raw = 1'b1; step(3);
        sw_raw = 1'b0; step(2);
        sw_raw = 1'b1;
        step(5);
        chk("sw_pre", {4'b0, sw_stable}, 5'b0);
        step(1);
        chk("sw_up", {4'b0, sw_stable}, 5'b1);
        step(3);

        // reset during D's repeat phase
        e0 = e;
        btn_raw[4] = 1'b1;
        push(e0 + 6, 5'b10000);
        push(e0 + 16, 5'b10000);
        push(e0 + 19, 5'b10000);
        step(20);
        chk("d_held_pre_rst", btn_held, 5'b10000);
        rst_n = 1'b0;
        #1;
        chk("arst_held", btn_held, 5'b0);
        chk("arst_pulse", btn_pulse, 5'b0);
        chk("arst_sw", {4'b0, sw_stable}, 5'b0);
        step(2);
        rst_n = 1'b1;
        e0 = e;
        push(e0 + 6, 5'b10000);
        push(e0 + 16, 5'b10000);
        step(5);
        chk("d_held_post_pre", btn_held, 5'b00000);
        step(1);
        chk("d_held_post", btn_held, 5'b10000);
        chk("sw_post", {4'b0, sw_stable}, 5'b1);
        step(6);
        btn_raw[4] = 1'b0;
        step(15);
        chk("d_held_rel", btn_held, 5'b00000);

        // simultaneous L and D
        e0 = e;
        btn_raw[1] = 1'b1;
        btn_raw[4] = 1'b1;
        push(e0 + 6, 5'b10010);
        for (int k = 16; k <= 22; k += 3) push(e0 + (k == 16 ? 16 : k), 5'b10000);
        step(6);
        chk("ld_held", btn_held, 5'b10010);
        step(4);
        btn_raw[1] = 1'b0;
        step(7);
        chk("ld_held_indep", btn_held, 5'b10000);
        btn_raw[4] = 1'b0;
        step(10);
        chk("ld_held_rel", btn_held, 5'b00000);
        step(5);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
